fmul_arbiter: RTL

Shares one pipelined single-precision multiplier (fixed latency, no stall) between two requesters, e.g. the integer core's FPU issue port and the load/store-side conversion path. Round-robin arbitration with valid/ready on the request side. A tag/owner shift pipeline matched to the multiplier latency routes each result back to the requester that issued it. A flush input kills in-flight operations.

---
 rtl/fmul_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin share of one pipelined fp multiplier between two requesters
// Optional stall counters: define FMUL_ARB_STALL_CNT_EN.
module fmul_arbiter #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x1,
  input  logic [31:0]      req0_x2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x1,
  input  logic [31:0]      req1_x2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             mul_valid,
  output logic [31:0]      mul_x1,
  output logic [31:0]      mul_x2,
  input  logic [31:0]      mul_y,
  output logic             resp0_valid,
  output logic [31:0]      resp0_y,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  output logic [31:0]      resp1_y,
  output logic [TAG_W-1:0] resp1_tag
`ifdef FMUL_ARB_STALL_CNT_EN
  ,
  output logic [31:0]      stall0_cnt,
  output logic [31:0]      stall1_cnt
`endif
);

  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic [LATENCY-1:0] slot_valid;
  logic [LATENCY-1:0] slot_owner;
  logic [TAG_W-1:0]   slot_tag [LATENCY];

  // Gating with rstn keeps ready/mul_valid low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rstn && !flush) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    mul_valid  = grant0 | grant1;
    mul_x1     = 32'd0;
    mul_x2     = 32'd0;
    if (grant0) begin
      mul_x1 = req0_x1;
      mul_x2 = req0_x2;
    end else if (grant1) begin
      mul_x1 = req1_x1;
      mul_x2 = req1_x2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant  <= 1'b1;
      slot_valid  <= '0;
      slot_owner  <= '0;
      for (int i = 0; i < LATENCY; i++) slot_tag[i] <= '0;
      resp0_valid <= 1'b0;
      resp0_y     <= 32'd0;
      resp0_tag   <= '0;
      resp1_valid <= 1'b0;
      resp1_y     <= 32'd0;
      resp1_tag   <= '0;
    end else begin
      if (grant0 || grant1) last_grant <= grant1;

      // Ownership pipeline tracks the multiplier stage by stage; flush drops every slot.
      slot_valid[0] <= (grant0 || grant1) && !flush;
      slot_owner[0] <= grant1;
      slot_tag[0]   <= grant1 ? req1_tag : req0_tag;
      for (int i = 1; i < LATENCY; i++) begin
        slot_valid[i] <= slot_valid[i-1] && !flush;
        slot_owner[i] <= slot_owner[i-1];
        slot_tag[i]   <= slot_tag[i-1];
      end

      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (slot_valid[LATENCY-1] && !flush) begin
        if (slot_owner[LATENCY-1]) begin
          resp1_valid <= 1'b1;
          resp1_y     <= mul_y;
          resp1_tag   <= slot_tag[LATENCY-1];
        end else begin
          resp0_valid <= 1'b1;
          resp0_y     <= mul_y;
          resp0_tag   <= slot_tag[LATENCY-1];
        end
      end
    end
  end

`ifdef FMUL_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall0_cnt <= 32'd0;
      stall1_cnt <= 32'd0;
    end else begin
      if (req0_valid && !req0_ready && stall0_cnt != 32'hFFFF_FFFF)
        stall0_cnt <= stall0_cnt + 32'd1;
      if (req1_valid && !req1_ready && stall1_cnt != 32'hFFFF_FFFF)
        stall1_cnt <= stall1_cnt + 32'd1;
    end
  end
`endif

endmodule
